// File: rtl/bios_arb_pkg.sv
// Shared types and parameter checks for the BIOS port-B arbiter and its round-robin helper.
package bios_arb_pkg;

    typedef enum logic [1:0] {
        SlotEmpty    = 2'd0,
        SlotInflight = 2'd1,
        SlotFull     = 2'd2
    } slot_e;

    localparam int NreqMin = 2;
    localparam int NreqMax = 4;

    function automatic bit nreq_ok(input int n);
        return (n >= NreqMin) && (n <= NreqMax);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr (wrapping) wins,
// next_ptr points just past the winner, or holds when nothing is eligible.
module rr_arbiter
    import bios_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] next_ptr
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                next_ptr    = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/bios_port_arbiter.sv
// Shares the BIOS memory read port B between NREQ requesters with round-robin grants and a
// one-entry response slot per requester, so a stalled consumer never blocks the others.
module bios_port_arbiter
    import bios_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_adr,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DATA_W-1:0]   rsp_data,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [ADDR_W-1:0]        mem_adrb,
    output logic                     mem_en_b,
    input  logic [DATA_W-1:0]        mem_doutb
);

    localparam int PTR_W = ptr_width(NREQ);

    if (!nreq_ok(NREQ)) begin : g_nreq_bad
        $error("bios_port_arbiter: NREQ must be within 2..4");
    end

    logic             run_q;
    logic             active;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_next;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;

    // No grants while in reset nor in the first cycle after release.
    assign active = reset & run_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            run_q <= 1'b1;
            ptr_q <= ptr_next;
        end
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .next_ptr (ptr_next)
    );

    assign req_ready = grant;
    assign mem_en_b  = |grant;

    always_comb begin
        mem_adrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mem_adrb = mem_adrb | req_adr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        slot_e             slot_q;
        logic [DATA_W-1:0] hold_q;

        // A slot can be refilled in the same cycle its current response is consumed.
        assign eligible[i] = active & req_valid[i] & ((slot_q == SlotEmpty) | rsp_ready[i]);
        assign rsp_valid[i] = reset & (slot_q != SlotEmpty);
        assign rsp_data[i*DATA_W +: DATA_W] = !rsp_valid[i]             ? '0        :
                                              (slot_q == SlotInflight)  ? mem_doutb : hold_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                slot_q <= SlotEmpty;
                hold_q <= '0;
            end else begin
                case (slot_q)
                    SlotEmpty: begin
                        if (grant[i]) slot_q <= SlotInflight;
                    end
                    SlotInflight: begin
                        if (rsp_ready[i]) begin
                            slot_q <= grant[i] ? SlotInflight : SlotEmpty;
                        end else begin
                            // Port data is overwritten by the next grant, so keep a copy.
                            slot_q <= SlotFull;
                            hold_q <= mem_doutb;
                        end
                    end
                    SlotFull: begin
                        if (rsp_ready[i]) slot_q <= grant[i] ? SlotInflight : SlotEmpty;
                    end
                    default: slot_q <= SlotEmpty;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Self-checking bench for bios_port_arbiter: scoreboard model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_bios_port_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_adr;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ*DATA_W-1:0] rsp_data;
    logic [NREQ-1:0]        rsp_ready;
    logic [ADDR_W-1:0]      mem_adrb;
    logic                   mem_en_b;
    logic [DATA_W-1:0]      mem_doutb = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    bios_port_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_adr   (req_adr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .mem_adrb  (mem_adrb),
        .mem_en_b  (mem_en_b),
        .mem_doutb (mem_doutb)
    );

    always #5 clk = ~clk;

    // Memory contents: a recognisable function of the word address.
    function automatic logic [31:0] memf(input logic [11:0] a);
        return {8'hB1, a, ~a};
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_en_b) mem_doutb <= memf(mem_adrb);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard model: per requester an outstanding response with its expected data,
    // and the requester index the rotation starts from.
    bit          m_run = 1'b0;
    bit          m_have [NREQ];
    logic [31:0] m_data [NREQ];
    int          m_next = 0;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            m_have[i] = 1'b0;
            m_data[i] = '0;
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0]        e_ready, e_valid;
        logic [NREQ*DATA_W-1:0] e_data;
        logic [ADDR_W-1:0]      e_adr;
        int                     g;
        g       = -1;
        e_ready = '0;
        e_valid = '0;
        e_data  = '0;
        e_adr   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (reset && m_have[i]) begin
                e_valid[i] = 1'b1;
                e_data[i*DATA_W +: DATA_W] = m_data[i];
            end
        end
        if (reset && m_run) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_next + k) % NREQ;
                if (g < 0 && req_valid[c] && (!m_have[c] || rsp_ready[c])) g = c;
            end
        end
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_adr      = req_adr[g*ADDR_W +: ADDR_W];
        end
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(e_valid));
        check("rsp_data", 64'(rsp_data), 64'(e_data));
        check("mem_en_b", 64'(mem_en_b), 64'(g >= 0));
        check("mem_adrb", 64'(mem_adrb), 64'(e_adr));
        if (!reset) begin
            m_run  = 1'b0;
            m_next = 0;
            for (int i = 0; i < NREQ; i++) m_have[i] = 1'b0;
        end else begin
            m_run = 1'b1;
            for (int i = 0; i < NREQ; i++) if (m_have[i] && rsp_ready[i]) m_have[i] = 1'b0;
            if (g >= 0) begin
                m_have[g] = 1'b1;
                m_data[g] = memf(e_adr);
                m_next    = (g + 1) % NREQ;
            end
        end
    end

    task automatic set_adr(input int i, input logic [ADDR_W-1:0] a);
        req_adr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] gr;
        reset     = 1'b0;
        req_valid = 2'b11;
        req_adr   = '0;
        rsp_ready = 2'b11;
        set_adr(0, 12'h010);
        set_adr(1, 12'h011);

        // Reset held with requests pending: nothing may be granted or reported.
        repeat (3) begin
            to_neg();
            check("rst req_ready", 64'(req_ready), 64'(2'b00));
            check("rst mem_en_b", 64'(mem_en_b), 64'(1'b0));
            check("rst rsp_valid", 64'(rsp_valid), 64'(2'b00));
            check("rst rsp_data", 64'(rsp_data), 64'h0);
            to_pos();
        end

        // First cycle after release still grants nothing.
        reset = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        to_neg();
        check("post-rst req_ready", 64'(req_ready), 64'(2'b00));
        to_pos();

        // Test 1: single requester streams at one per cycle.
        for (int c = 0; c < 6; c++) begin
            to_neg();
            check("t1 req_ready", 64'(req_ready), 64'(2'b01));
            if (c > 0) begin
                check("t1 rsp_valid0", 64'(rsp_valid[0]), 64'(1'b1));
                check("t1 rsp_data0", 64'(rsp_data[31:0]), 64'h0000_0000_B101_0FEF);
            end
            to_pos();
        end

        // Test 2: contention alternates grants.
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        set_adr(0, 12'h012);
        set_adr(1, 12'h013);
        for (int c = 0; c < 6; c++) begin
            to_neg();
            check("t2 grant", 64'(req_ready), (c % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            if (c == 1) check("t2 rsp_data1", 64'(rsp_data[63:32]), 64'hB101_3FEC);
            to_pos();
        end

        req_valid = 2'b00;
        repeat (2) to_pos();

        // Test 3: req1 stalls its response while req0 streams.
        req_valid = 2'b10;
        set_adr(1, 12'h020);
        to_neg();
        check("t3 grant1", 64'(req_ready), 64'(2'b10));
        to_pos();
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        set_adr(1, 12'h050);
        for (int c = 0; c < 5; c++) begin
            set_adr(0, ADDR_W'(12'h030 + c));
            to_neg();
            check("t3 req_ready", 64'(req_ready), 64'(2'b01));
            check("t3 rsp_valid1", 64'(rsp_valid[1]), 64'(1'b1));
            check("t3 rsp_data1", 64'(rsp_data[63:32]), 64'hB102_0FDF);
            to_pos();
        end

        // Test 4: consume and re-request in the same cycle.
        rsp_ready = 2'b11;
        set_adr(0, 12'h035);
        set_adr(1, 12'h040);
        to_neg();
        check("t4 grant", 64'(req_ready), 64'(2'b10));
        check("t4 held data", 64'(rsp_data[63:32]), 64'hB102_0FDF);
        to_pos();
        req_valid = 2'b00;
        to_neg();
        check("t4 rsp_valid", 64'(rsp_valid), 64'(2'b10));
        check("t4 new data", 64'(rsp_data[63:32]), 64'hB104_0FBF);
        to_pos();

        // Test 5: reset with an access in flight.
        req_valid = 2'b01;
        set_adr(0, 12'h060);
        to_neg();
        check("t5 grant0", 64'(req_ready), 64'(2'b01));
        to_pos();
        reset = 1'b0;
        req_valid = 2'b11;
        to_neg();
        check("t5 rst rsp_valid", 64'(rsp_valid), 64'(2'b00));
        check("t5 rst mem_en_b", 64'(mem_en_b), 64'(1'b0));
        to_pos();
        reset = 1'b1;
        to_neg();
        check("t5 post req_ready", 64'(req_ready), 64'(2'b00));
        check("t5 post rsp_valid", 64'(rsp_valid), 64'(2'b00));
        to_pos();
        to_neg();
        check("t5 first grant", 64'(req_ready), 64'(2'b01));
        to_pos();

        // Test 6: idle keeps the port quiet and the pointer where it was.
        req_valid = 2'b00;
        repeat (10) begin
            to_neg();
            check("t6 mem_en_b", 64'(mem_en_b), 64'(1'b0));
            check("t6 mem_adrb", 64'(mem_adrb), 64'h0);
            to_pos();
        end
        req_valid = 2'b11;
        to_neg();
        check("t6 ptr kept", 64'(req_ready), 64'(2'b10));
        to_pos();

        // Protocol-respecting random traffic, checked by the model.
        for (int c = 0; c < 300; c++) begin
            to_neg();
            gr = req_ready;
            to_pos();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || gr[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_adr(i, ADDR_W'($urandom));
                end
            end
            rsp_ready = NREQ'($urandom);
        end

        to_neg();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
